// File: rtl/bram_rr_arbiter_pkg.sv
// rtl/bram_rr_arbiter_pkg.sv - shared types and helpers for the BRAM round-robin arbiter
// Round-robin pick works on a fixed MAX_REQ-wide vector; callers truncate to their own width.
package bram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(MAX_REQ);

  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] rot;
    int                 idx;
    logic               found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx -= n;
      rot = valid >> idx;
      if ((k < n) && !found && rot[0]) begin
        rr_pick = MAX_REQ'(1) << idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// rtl/bram_rd_tag_pipe.sv - {valid,id} delay line matching the BRAM read latency
// Tail entry marks which requester owns the bram_dout word of the current cycle.
module bram_rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int ID_W  = 2
) (
  input  logic            axi_clock,
  input  logic            rst,
  input  logic            push_valid,
  input  logic [ID_W-1:0] push_id,
  output logic            tail_valid,
  output logic [ID_W-1:0] tail_id,
  output logic            any_valid
);

  logic [DEPTH-1:0]           vld;
  logic [DEPTH-1:0][ID_W-1:0] ids;

  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      vld <= '0;
      ids <= '0;
    end else begin
      vld[0] <= push_valid;
      ids[0] <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

  assign tail_valid = vld[DEPTH-1];
  assign tail_id    = ids[DEPTH-1];
  assign any_valid  = |vld;

endmodule

// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - round-robin single-port BRAM sharing with burst lock and read routing
// resp_data passes bram_dout straight through; BRAM_LATENCY already includes any BRAM output register.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int BRAM_LATENCY = 1
) (
  input  logic                          axi_clock,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic                          busy
);

  localparam int IDW = id_width(NUM_REQ);

  arb_state_e         state, state_nxt;
  logic [IDW-1:0]     owner, owner_nxt;
  logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [MAX_REQ-1:0] valid_ext;
  logic [NUM_REQ-1:0] pick;
  logic               accept;
  logic [IDW-1:0]     win;
  logic               win_last;
  logic [IDW-1:0]     sel;
  logic               tail_valid;
  logic [IDW-1:0]     tail_id;
  logic               pipe_any;

  // Grant: owner-only while locked, otherwise first valid from rr_ptr onward.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
    pick                     = NUM_REQ'(rr_pick(valid_ext, int'(rr_ptr), NUM_REQ));
    req_ready                = '0;
    if (state == LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (owner == IDW'(i)) req_ready[i] = req_valid[i];
    end else begin
      req_ready = pick;
    end
    accept   = |req_ready;
    win      = '0;
    win_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win      = IDW'(i);
        win_last = req_last[i];
      end
    end
  end

  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    if (accept) begin
      if (win_last) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
      end else begin
        state_nxt = LOCKED;
        owner_nxt = win;
      end
    end
  end

  // Idle cycles park the address/data mux on rr_ptr's slice.
  always_comb begin
    sel       = accept ? win : rr_ptr;
    bram_en   = accept;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) begin
        bram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bram_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
        bram_we   = accept & req_we[i];
      end
    end
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = tail_valid && (tail_id == IDW'(i));
    resp_data = bram_dout;
    busy      = (state == LOCKED) | pipe_any;
  end

  bram_rd_tag_pipe #(
    .DEPTH (BRAM_LATENCY),
    .ID_W  (IDW)
  ) u_tag_pipe (
    .axi_clock  (axi_clock),
    .rst        (rst),
    .push_valid (accept & ~bram_we),
    .push_id    (win),
    .tail_valid (tail_valid),
    .tail_id    (tail_id),
    .any_valid  (pipe_any)
  );

endmodule
